// File: rtl/pc_pkg.sv
// Shared definitions for the program counter / return-address-stack unit:
// next-PC source encodings and the RAS occupancy-count width helper.
package pc_pkg;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_JUMP = 2'b01;
    localparam logic [1:0] PC_CALL = 2'b10;
    localparam logic [1:0] PC_RET  = 2'b11;

    // Count must represent 0..depth inclusive, hence one extra bit.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and a pop when empty is ignored; both cases raise err_c.
module ras_stack
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [ADDR_W-1:0]             push_data,
    output logic [ADDR_W-1:0]             top,
    output logic [cnt_w(RAS_DEPTH)-1:0]   count,
    output logic                          full,
    output logic                          empty,
    output logic                          err_c
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = cnt_w(RAS_DEPTH);

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [ADDR_W-1:0] mem_d [RAS_DEPTH];
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     count_q, count_d;

    assign count = count_q;
    assign full  = (count_q == CW'(RAS_DEPTH));
    assign empty = (count_q == '0);
    assign top   = mem_q[ptr_q - PW'(1)];
    assign err_c = (push && full) || (pop && empty);

    // Pointer wraps naturally because RAS_DEPTH is a power of two.
    always_comb begin
        mem_d   = mem_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PW'(1);
            if (!full) begin
                count_d = count_q + CW'(1);
            end
        end else if (pop && !empty) begin
            ptr_d   = ptr_q - PW'(1);
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Entry contents need no reset; count gates their validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/program_counter_ras_unit.sv
// Program counter with SEQ/JUMP/CALL/RET next-PC selection, stall and a return-address
// stack. Define PC_MISALIGN_CHECK_EN to reject targets not aligned to INC.
module program_counter_ras_unit
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int unsigned       INC          = 1,
    parameter int unsigned       RAS_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic [1:0]                  pc_sel,
    input  logic [ADDR_W-1:0]           next_address,
    output logic [ADDR_W-1:0]           PCin,
    output logic [cnt_w(RAS_DEPTH)-1:0] ras_count,
    output logic                        ras_empty,
    output logic                        ras_full,
    output logic                        ras_err,
    output logic                        misalign
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] seq;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_err_q, ras_err_d;
    logic              misalign_q, misalign_d;
    logic              push, pop, stk_err_c;

`ifdef PC_MISALIGN_CHECK_EN
    function automatic logic is_aligned(input logic [ADDR_W-1:0] a);
        return (a & ADDR_W'(INC - 1)) == '0;
    endfunction
`endif

    assign seq      = pc_q + ADDR_W'(INC);
    assign PCin     = pc_q;
    assign ras_err  = ras_err_q;
    assign misalign = misalign_q;

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (seq),
        .top       (ras_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty),
        .err_c     (stk_err_c)
    );

    // Next-PC mux; stall suppresses all stack activity and error pulses.
    always_comb begin
        pc_d       = pc_q;
        push       = 1'b0;
        pop        = 1'b0;
        misalign_d = 1'b0;
        if (!stall) begin
            case (pc_sel)
                PC_SEQ:  pc_d = seq;
                PC_JUMP: begin
                    pc_d = next_address;
`ifdef PC_MISALIGN_CHECK_EN
                    if (!is_aligned(next_address)) begin
                        pc_d       = seq;
                        misalign_d = 1'b1;
                    end
`endif
                end
                PC_CALL: begin
                    pc_d = next_address;
                    push = 1'b1;
`ifdef PC_MISALIGN_CHECK_EN
                    if (!is_aligned(next_address)) begin
                        pc_d       = seq;
                        push       = 1'b0;
                        misalign_d = 1'b1;
                    end
`endif
                end
                default: begin
                    pop  = 1'b1;
                    pc_d = ras_empty ? seq : ras_top;
`ifdef PC_MISALIGN_CHECK_EN
                    if (!ras_empty && !is_aligned(ras_top)) begin
                        pc_d       = seq;
                        misalign_d = 1'b1;
                    end
`endif
                end
            endcase
        end
        ras_err_d = stk_err_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_VECTOR;
            ras_err_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ras_err_q  <= ras_err_d;
            misalign_q <= misalign_d;
        end
    end

endmodule
